// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of one shared block memory.
// Zero-latency pass-through of the granted side, round-robin or fixed D priority.
module mem_arbiter #(
  parameter bit RR    = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             proc_reset,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic [27:0]      i_mem_addr,
  input  logic [127:0]     i_mem_wdata,
  output logic [127:0]     i_mem_rdata,
  output logic             i_mem_ready,
  input  logic             d_mem_read,
  input  logic             d_mem_write,
  input  logic [27:0]      d_mem_addr,
  input  logic [127:0]     d_mem_wdata,
  output logic [127:0]     d_mem_rdata,
  output logic             d_mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic [27:0]      mem_addr,
  output logic [127:0]     mem_wdata,
  input  logic [127:0]     mem_rdata,
  input  logic             mem_ready,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] i_txn_cnt,
  output logic [CNT_W-1:0] d_txn_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  state_t state, state_nxt;
  logic   last_d;
  logic   any_served;  // nothing completed since reset: I gets the first tie
  logic   i_pend, d_pend;
  logic   i_done, d_done;

  assign i_pend      = i_mem_read | i_mem_write;
  assign d_pend      = d_mem_read | d_mem_write;
  assign grant       = {state == GNT_D, state == GNT_I};
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state      <= IDLE;
      last_d     <= 1'b0;
      any_served <= 1'b0;
      i_txn_cnt  <= '0;
      d_txn_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (i_done || d_done) any_served <= 1'b1;
      if (i_done) last_d <= 1'b0;
      else if (d_done) last_d <= 1'b1;
      if (i_done && !(&i_txn_cnt)) i_txn_cnt <= i_txn_cnt + CNT_W'(1);
      if (d_done && !(&d_txn_cnt)) d_txn_cnt <= d_txn_cnt + CNT_W'(1);
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_nxt   = state;
    i_done      = 1'b0;
    d_done      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend && d_pend)
          state_nxt = (RR && (last_d || !any_served)) ? GNT_I : GNT_D;
        else if (i_pend)
          state_nxt = GNT_I;
        else if (d_pend)
          state_nxt = GNT_D;
      end
      GNT_I: begin
        mem_read    = i_mem_read;
        mem_write   = i_mem_write;
        mem_addr    = i_mem_addr;
        mem_wdata   = i_mem_wdata;
        i_mem_ready = mem_ready;
        if (mem_ready) begin
          state_nxt = IDLE;
          i_done    = 1'b1;
        end else if (!i_pend) begin
          state_nxt = IDLE;
        end
      end
      GNT_D: begin
        mem_read    = d_mem_read;
        mem_write   = d_mem_write;
        mem_addr    = d_mem_addr;
        mem_wdata   = d_mem_wdata;
        d_mem_ready = mem_ready;
        if (mem_ready) begin
          state_nxt = IDLE;
          d_done    = 1'b1;
        end else if (!d_pend) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: round-robin instance (a_*) plus a
// fixed-priority instance with a 2-bit counter (b_*) for priority and saturation.
module tb_mem_arbiter;

  localparam logic [27:0]  I_ADDR = 28'h0000010;
  localparam logic [27:0]  D_ADDR = 28'h0000ABC;
  localparam logic [127:0] I_WD   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D_WD   = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123_4567;
  localparam logic [1:0]   OWN_I  = 2'b01;
  localparam logic [1:0]   OWN_D  = 2'b10;

  logic clk = 1'b0;
  logic proc_reset = 1'b1;
  logic ir = 0, iw = 0, dr = 0, dw = 0, mem_ready = 0;
  logic [127:0] mem_rdata = '0;

  logic [127:0] a_i_rdata, a_d_rdata, a_wdata, b_i_rdata, b_d_rdata, b_wdata;
  logic         a_i_rdy, a_d_rdy, a_mr, a_mw, b_i_rdy, b_d_rdy, b_mr, b_mw;
  logic [27:0]  a_addr, b_addr;
  logic [1:0]   a_grant, b_grant;
  logic [15:0]  a_icnt, a_dcnt;
  logic [1:0]   b_icnt, b_dcnt;

  int checks = 0;
  int errors = 0;
  logic [1:0] sb[$];

  always #5 clk = ~clk;

  mem_arbiter #(.RR(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(ir), .i_mem_write(iw), .i_mem_addr(I_ADDR), .i_mem_wdata(I_WD),
    .i_mem_rdata(a_i_rdata), .i_mem_ready(a_i_rdy),
    .d_mem_read(dr), .d_mem_write(dw), .d_mem_addr(D_ADDR), .d_mem_wdata(D_WD),
    .d_mem_rdata(a_d_rdata), .d_mem_ready(a_d_rdy),
    .mem_read(a_mr), .mem_write(a_mw), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(a_grant), .i_txn_cnt(a_icnt), .d_txn_cnt(a_dcnt)
  );

  mem_arbiter #(.RR(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(ir), .i_mem_write(iw), .i_mem_addr(I_ADDR), .i_mem_wdata(I_WD),
    .i_mem_rdata(b_i_rdata), .i_mem_ready(b_i_rdy),
    .d_mem_read(dr), .d_mem_write(dw), .d_mem_addr(D_ADDR), .d_mem_wdata(D_WD),
    .d_mem_rdata(b_d_rdata), .d_mem_ready(b_d_rdy),
    .mem_read(b_mr), .mem_write(b_mw), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(b_grant), .i_txn_cnt(b_icnt), .d_txn_cnt(b_dcnt)
  );

  typedef struct {
    logic ir, iw, dr, dw, rdy;
    logic [1:0] grant;
    logic mr, mw;
    logic [27:0] addr;
    logic i_rdy, d_rdy;
    int icnt, dcnt;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Negedge sample point; any completion strobe on instance a is scored here.
  task automatic mon();
    logic [1:0] got;
    @(negedge clk);
    if (!proc_reset && (a_i_rdy || a_d_rdy)) begin
      got = {a_d_rdy, a_i_rdy};
      if (sb.size() == 0) check("sb_unexpected_ready", got, 2'b00);
      else check("sb_owner", got, sb.pop_front());
    end
  endtask

  task automatic cyc();
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    ir = 0; iw = 0; dr = 0; dw = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    #1 proc_reset = 1'b0;
  endtask

  // Wait (bounded) for a grant on instance a, then complete it with one mem_ready pulse.
  task automatic serve(input logic [1:0] owner);
    int n;
    n = 0;
    forever begin
      mon();
      if (a_grant != 2'b00 || n >= 8) break;
      @(posedge clk);
      #1;
      n++;
    end
    check("serve_grant", a_grant, owner);
    @(posedge clk);
    #1 mem_ready = 1'b1;
    sb.push_back(owner);
    mon();
    @(posedge clk);
    #1 mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    logic [127:0] exp_wd;

    tbl[0]  = '{0,0,0,0,0, 2'b00, 0,0, 28'h0,   0,0, 0,0};
    tbl[1]  = '{0,0,0,0,1, 2'b00, 0,0, 28'h0,   0,0, 0,0};
    tbl[2]  = '{1,0,0,1,0, 2'b00, 0,0, 28'h0,   0,0, 0,0};
    tbl[3]  = '{1,0,0,1,0, 2'b01, 1,0, I_ADDR,  0,0, 0,0};
    tbl[4]  = '{1,0,0,1,1, 2'b01, 1,0, I_ADDR,  1,0, 0,0};
    tbl[5]  = '{1,0,0,1,0, 2'b00, 0,0, 28'h0,   0,0, 1,0};
    tbl[6]  = '{1,0,0,1,0, 2'b10, 0,1, D_ADDR,  0,0, 1,0};
    tbl[7]  = '{1,0,1,1,1, 2'b10, 1,1, D_ADDR,  0,1, 1,0};
    tbl[8]  = '{1,0,1,0,0, 2'b00, 0,0, 28'h0,   0,0, 1,1};
    tbl[9]  = '{1,0,1,0,0, 2'b01, 1,0, I_ADDR,  0,0, 1,1};
    tbl[10] = '{0,0,1,0,0, 2'b01, 0,0, I_ADDR,  0,0, 1,1};
    tbl[11] = '{1,0,1,0,1, 2'b00, 0,0, 28'h0,   0,0, 1,1};
    tbl[12] = '{1,1,1,0,0, 2'b01, 1,1, I_ADDR,  0,0, 1,1};

    // Outputs while reset is held, then after release.
    #2;
    check("rst_grant", a_grant, 2'b00);
    check("rst_mem_write", a_mw, 1'b0);
    do_reset();
    mon();
    check("rst_icnt", a_icnt, 0);
    check("rst_dcnt", a_dcnt, 0);
    check("rst_b_dcnt", b_dcnt, 0);
    @(posedge clk);
    #1;

    // Cycle-by-cycle table on the round-robin instance.
    for (int i = 0; i < 13; i++) begin
      ir = tbl[i].ir; iw = tbl[i].iw; dr = tbl[i].dr; dw = tbl[i].dw;
      mem_ready = tbl[i].rdy;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (tbl[i].i_rdy || tbl[i].d_rdy) sb.push_back({tbl[i].d_rdy, tbl[i].i_rdy});
      exp_wd = (tbl[i].grant == OWN_I) ? I_WD : (tbl[i].grant == OWN_D) ? D_WD : '0;
      mon();
      check($sformatf("v%0d_grant", i), a_grant, tbl[i].grant);
      check($sformatf("v%0d_mem_read", i), a_mr, tbl[i].mr);
      check($sformatf("v%0d_mem_write", i), a_mw, tbl[i].mw);
      check($sformatf("v%0d_mem_addr", i), a_addr, tbl[i].addr);
      check($sformatf("v%0d_mem_wdata", i), a_wdata, exp_wd);
      check($sformatf("v%0d_i_ready", i), a_i_rdy, tbl[i].i_rdy);
      check($sformatf("v%0d_d_ready", i), a_d_rdy, tbl[i].d_rdy);
      check($sformatf("v%0d_icnt", i), a_icnt, 16'(tbl[i].icnt));
      check($sformatf("v%0d_dcnt", i), a_dcnt, 16'(tbl[i].dcnt));
      check($sformatf("v%0d_i_rdata", i), a_i_rdata, mem_rdata);
      check($sformatf("v%0d_d_rdata", i), a_d_rdata, mem_rdata);
      @(posedge clk);
      #1;
    end

    // Lone I read, memory answers on the third granted cycle.
    do_reset();
    ir = 1'b1;
    mon();
    check("ird_idle_grant", a_grant, 2'b00);
    @(posedge clk);
    #1;
    mon();
    check("ird_grant", a_grant, OWN_I);
    check("ird_addr", a_addr, 28'h0000010);
    check("ird_ready_low", a_i_rdy, 1'b0);
    @(posedge clk);
    #1;
    mon();
    @(posedge clk);
    #1 mem_ready = 1'b1;
    sb.push_back(OWN_I);
    mon();
    check("ird_ready", a_i_rdy, 1'b1);
    @(posedge clk);
    #1 mem_ready = 1'b0; ir = 1'b0;
    mon();
    check("ird_done_grant", a_grant, 2'b00);
    check("ird_icnt", a_icnt, 1);
    @(posedge clk);
    #1;

    // Simultaneous I read / D write: round-robin picks I, fixed priority picks D.
    do_reset();
    ir = 1'b1; dw = 1'b1;
    cyc();
    mon();
    check("tie_a_grant", a_grant, OWN_I);
    check("tie_b_grant", b_grant, OWN_D);
    check("tie_b_mem_write", b_mw, 1'b1);
    check("tie_b_addr", b_addr, D_ADDR);
    @(posedge clk);
    #1 mem_ready = 1'b1;
    sb.push_back(OWN_I);
    mon();
    check("tie_a_d_ready", a_d_rdy, 1'b0);
    check("tie_b_d_ready", b_d_rdy, 1'b1);
    check("tie_b_i_ready", b_i_rdy, 1'b0);
    @(posedge clk);
    #1 mem_ready = 1'b0; ir = 1'b0;
    mon();
    check("tie_turnaround", a_grant, 2'b00);
    @(posedge clk);
    #1;
    serve(OWN_D);
    dw = 1'b0;
    cyc();

    // D write-back then allocate while I stays pending: D, I, D.
    do_reset();
    dw = 1'b1;
    cyc();
    ir = 1'b1;
    serve(OWN_D);
    dw = 1'b0; dr = 1'b1;
    serve(OWN_I);
    ir = 1'b0;
    serve(OWN_D);
    dr = 1'b0;
    mon();
    check("wb_icnt", a_icnt, 1);
    check("wb_dcnt", a_dcnt, 2);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a D grant.
    dw = 1'b1;
    serve(OWN_D);
    cyc();
    mon();
    check("arst_pre_grant", a_grant, OWN_D);
    check("arst_pre_write", a_mw, 1'b1);
    #2 proc_reset = 1'b1;
    #1;
    check("arst_grant", a_grant, 2'b00);
    check("arst_mem_write", a_mw, 1'b0);
    check("arst_d_ready", a_d_rdy, 1'b0);
    check("arst_icnt", a_icnt, 0);
    check("arst_dcnt", a_dcnt, 0);
    #1 proc_reset = 1'b0;
    @(posedge clk);
    #1;
    serve(OWN_D);
    mon();
    check("arst_reissue_dcnt", a_dcnt, 1);
    @(posedge clk);
    #1;

    // Saturation on the 2-bit counter, then a withdrawn request.
    do_reset();
    dw = 1'b1;
    serve(OWN_D);
    serve(OWN_D);
    mon();
    check("sat_b_max_minus_1", b_dcnt, 2'b10);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) serve(OWN_D);
    mon();
    check("sat_b_dcnt", b_dcnt, 2'b11);
    check("sat_a_dcnt", a_dcnt, 5);
    @(posedge clk);
    #1;
    mon();
    check("wd_grant", a_grant, OWN_D);
    @(posedge clk);
    #1 dw = 1'b0;
    mon();
    check("wd_ready_low", a_d_rdy, 1'b0);
    @(posedge clk);
    #1;
    mon();
    check("wd_idle", a_grant, 2'b00);
    check("wd_b_dcnt", b_dcnt, 2'b11);
    check("wd_a_dcnt", a_dcnt, 5);
    @(posedge clk);
    #1;

    check("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
